memory_responder: RTL and testbench

//  Memory-side end of the CPU fetch/load/store handshake. Accepts readM/writeM strobes with an

---
 rtl/memory_responder_pkg.sv | 18 +
 rtl/memory_responder_if.sv | 28 ++
 rtl/memory_responder_mem_array.sv | 26 ++
 rtl/memory_responder.sv | 102 ++++++++++
 tb/tb_memory_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default
// bus geometry and the latency counter width.
package memory_responder_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int DEFAULT_ADDR_W    = 8;
  localparam int DEFAULT_LATENCY   = 2;

  // Wide enough for the largest legal latency (15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_HOLD = 2'd2
  } mem_state_t;

endpackage

// File: rtl/memory_responder_if.sv
// CPU <-> memory fetch/load/store handshake. The master drives strobes and
// address/data; the slave (memory) returns data and the response pulses.
interface memory_responder_if
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) ();

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] data_in;
  logic [WORD_SIZE-1:0] data_out;
  logic                 inputReady;
  logic                 ackOutput;
  logic                 busy;

  modport master (
    output readM, writeM, address, data_in,
    input  data_out, inputReady, ackOutput, busy
  );

  modport slave (
    input  readM, writeM, address, data_in,
    output data_out, inputReady, ackOutput, busy
  );

endinterface

// File: rtl/memory_responder_mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read through a
// single shared index. Contents are never cleared by reset.
module memory_responder_mem_array
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    idx,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: accepts a read/write strobe, waits LATENCY cycles,
// then answers with a one-cycle inputReady (read) or ackOutput (write) pulse.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic                clk,
  input  logic                reset_n,
  memory_responder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t           state;
  mem_state_t           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 op_rd;
  logic [ADDR_W-1:0]    idx;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 accept;
  logic                 complete;
  logic                 rd_done;
  logic                 wr_done;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] rd_data;

  // State register, latency counter and registered response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= MEM_IDLE;
      cnt             <= '0;
      bus.data_out    <= '0;
      bus.inputReady  <= 1'b0;
      bus.ackOutput   <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.inputReady  <= rd_done;
      bus.ackOutput   <= wr_done;
      if (rd_done) begin
        bus.data_out  <= rd_data;
      end
    end
  end

  // Request latches: plain data, captured only at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_rd   <= bus.readM;
      idx     <= bus.address[ADDR_W-1:0];
      wdata_q <= bus.data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MEM_IDLE: if (bus.readM || bus.writeM) state_nxt = MEM_BUSY;
      MEM_BUSY: if (cnt == '0)               state_nxt = MEM_HOLD;
      MEM_HOLD: if (!bus.readM && !bus.writeM) state_nxt = MEM_IDLE;
      default:                               state_nxt = MEM_IDLE;
    endcase
  end

  // A simultaneous read/write is latched as a read, so the write is dropped
  always_comb begin
    accept   = (state == MEM_IDLE) && (bus.readM || bus.writeM);
    complete = (state == MEM_BUSY) && (cnt == '0);
    rd_done  = complete && op_rd;
    wr_done  = complete && !op_rd;
    mem_we   = wr_done && reset_n;
    cnt_nxt  = cnt;
    if (accept) begin
      cnt_nxt = CNT_LOAD;
    end else if ((state == MEM_BUSY) && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  assign bus.busy = (state != MEM_IDLE);

  if (WORD_SIZE > ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_W];
  end

  memory_responder_mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (LATENCY 2 and 1) share stimulus
// and are checked every cycle against a timestamp-based transaction model.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  memory_responder_if #(.WORD_SIZE(16)) if0 ();
  memory_responder_if #(.WORD_SIZE(16)) if1 ();

  assign if0.readM = rd;   assign if1.readM = rd;
  assign if0.writeM = wr;  assign if1.writeM = wr;
  assign if0.address = addr; assign if1.address = addr;
  assign if0.data_in = din;  assign if1.data_in = din;

  memory_responder #(.WORD_SIZE(16), .ADDR_W(8), .LATENCY(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  memory_responder #(.WORD_SIZE(16), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  logic [1:0]  ir_w, ack_w, busy_w;
  logic [15:0] dout_w [2];
  assign ir_w   = {if1.inputReady, if0.inputReady};
  assign ack_w  = {if1.ackOutput,  if0.ackOutput};
  assign busy_w = {if1.busy,       if0.busy};
  assign dout_w[0] = if0.data_out;
  assign dout_w[1] = if1.data_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: a request accepted at edge c0 answers at edge c0+L,
  // then the responder waits for both strobes low before taking another.
  int          lat_of [2] = '{2, 1};
  logic [15:0] mmem [2][256];
  bit          m_active [2];
  bit          m_responded [2];
  int          m_done_at [2];
  bit          m_rd [2];
  logic [7:0]  m_idx [2];
  logic [15:0] m_wd [2];
  logic        exp_ir [2], exp_ack [2], exp_busy [2];
  logic [15:0] exp_dout [2];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) begin
          m_active[d] = 0; m_responded[d] = 0;
          exp_ir[d] = 0; exp_ack[d] = 0; exp_dout[d] = '0;
        end else begin
          exp_ir[d] = 0; exp_ack[d] = 0;
          if (!m_active[d]) begin
            if (rd || wr) begin
              m_active[d] = 1; m_responded[d] = 0;
              m_done_at[d] = cyc + lat_of[d];
              m_rd[d] = rd; m_idx[d] = addr[7:0]; m_wd[d] = din;
            end
          end else if (!m_responded[d]) begin
            if (cyc == m_done_at[d]) begin
              if (m_rd[d]) begin
                exp_ir[d] = 1; exp_dout[d] = mmem[d][m_idx[d]];
              end else begin
                exp_ack[d] = 1; mmem[d][m_idx[d]] = m_wd[d];
              end
              m_responded[d] = 1;
            end
          end else if (!rd && !wr) begin
            m_active[d] = 0;
          end
        end
        exp_busy[d] = m_active[d];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("dut%0d_inputReady", d), 32'(ir_w[d]),   32'(exp_ir[d]));
          chk($sformatf("dut%0d_ackOutput", d),  32'(ack_w[d]),  32'(exp_ack[d]));
          chk($sformatf("dut%0d_busy", d),       32'(busy_w[d]), 32'(exp_busy[d]));
          chk($sformatf("dut%0d_data_out", d),   32'(dout_w[d]), 32'(exp_dout[d]));
        end
      end
    end
  end

  // Issue one request and wait (bounded) for dut0's response
  task automatic do_req(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit early, output int lat0, output int lat1,
                        output logic [15:0] dout0, output logic [15:0] dout1, output bit was_ack);
    int  acc;
    bit  got;
    got = 0; lat0 = -1; lat1 = -1; dout0 = 'x; dout1 = 'x; was_ack = 0;
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d; acc = cyc + 1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if ((ir_w[1] || ack_w[1]) && lat1 < 0) begin
        lat1 = cyc - acc; dout1 = dout_w[1];
      end
      if (ir_w[0] || ack_w[0]) begin
        got = 1; lat0 = cyc - acc; dout0 = dout_w[0]; was_ack = ack_w[0];
        break;
      end
      if (early) begin rd = 0; wr = 0; end
    end
    rd = 0; wr = 0;
    if (!got) chk("response_timeout", 0, 1);
  endtask

  logic [15:0] pre [256];
  int          l0, l1;
  logic [15:0] q0, q1;
  bit          ack;
  int          pulses;
  bit          busy_ok;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_w[0]), 0);
    chk("reset_data_out", 32'(dout_w[0]), 0);
    chk("reset_inputReady", 32'(ir_w[0]), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      pre[i] = 16'($urandom);
      if (i == 5) pre[i] = 16'h1234;
      if (i == 32'h20 && pre[i] == 16'hAAAA) pre[i] = 16'h5555;
      do_req(0, 1, 16'(i), pre[i], 0, l0, l1, q0, q1, ack);
    end

    // 1: read latency and data
    do_req(1, 0, 16'h0005, 16'h0, 0, l0, l1, q0, q1, ack);
    chk("s1_latency_L2", 32'(l0), 2);
    chk("s1_latency_L1", 32'(l1), 1);
    chk("s1_data_L2", 32'(q0), 32'h1234);
    chk("s1_data_L1", 32'(q1), 32'h1234);
    chk("s1_no_ack", 32'(ack), 0);

    // 2: write then read back
    do_req(0, 1, 16'h0010, 16'hBEEF, 0, l0, l1, q0, q1, ack);
    chk("s2_write_ack", 32'(ack), 1);
    chk("s2_write_latency", 32'(l0), 2);
    do_req(1, 0, 16'h0010, 16'h0, 0, l0, l1, q0, q1, ack);
    chk("s2_readback", 32'(q0), 32'hBEEF);

    // 3: held strobe is serviced once
    @(negedge clk);
    rd = 1; addr = 16'h0033; pulses = 0; busy_ok = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      pulses += int'(ir_w[0]);
      if (!busy_w[0]) busy_ok = 0;
    end
    chk("s3_single_pulse", 32'(pulses), 1);
    chk("s3_busy_held", 32'(busy_ok), 1);
    rd = 0;
    @(negedge clk);
    chk("s3_busy_drops", 32'(busy_w[0]), 0);
    rd = 1; addr = 16'h0005;
    @(negedge clk);
    chk("s3_new_accept", 32'(busy_w[0]), 1);
    repeat (2) @(negedge clk);
    chk("s3_new_response", 32'(dout_w[0]), 32'h1234);
    rd = 0;
    repeat (2) @(negedge clk);

    // 4: simultaneous strobes act as a read
    do_req(1, 1, 16'h0005, 16'h0000, 0, l0, l1, q0, q1, ack);
    chk("s4_data", 32'(q0), 32'h1234);
    chk("s4_no_ack", 32'(ack), 0);
    do_req(1, 0, 16'h0005, 16'h0, 0, l0, l1, q0, q1, ack);
    chk("s4_mem_unchanged", 32'(q0), 32'h1234);

    // 5: reset at the completion edge aborts the write in dut0
    @(negedge clk);
    wr = 1; addr = 16'h0020; din = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0; wr = 0;
    @(negedge clk);
    chk("s5_no_ack", 32'(ack_w[0]), 0);
    chk("s5_busy", 32'(busy_w[0]), 0);
    chk("s5_data_out", 32'(dout_w[0]), 0);
    reset_n = 1;
    do_req(1, 0, 16'h0020, 16'h0, 0, l0, l1, q0, q1, ack);
    chk("s5_old_value", 32'(q0), 32'(pre[32'h20]));
    chk("s5_L1_committed", 32'(q1), 32'hAAAA);

    // 6: upper address bits ignored
    do_req(1, 0, 16'h0105, 16'h0, 0, l0, l1, q0, q1, ack);
    chk("s6_wrap", 32'(q0), 32'h1234);
    chk("s6_latency_L1", 32'(l1), 1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int  op;
      bit  early;
      op = $urandom_range(0, 2);
      early = ($urandom_range(0, 3) == 0);
      do_req(op != 1, op != 0, 16'($urandom), 16'($urandom), early, l0, l1, q0, q1, ack);
      chk("rand_latency", 32'(l0), 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
